// File: rtl/relay_fifo.sv
// relay_fifo: byte FIFO between the UART receiver and transmitter with a start/ready drain FSM.
module relay_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              tx_ready,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              overflow
);
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LAUNCH    = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [1:0]        state, state_nx;
  logic              pop, push;
  logic [ADDR_W:0]   count_nx;
  always_comb begin
    pop      = (state == IDLE) && !empty && tx_ready;
    // a full FIFO still accepts a byte when the same cycle frees an entry
    push     = in_valid && (!full || pop);
    count_nx = count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
    state_nx = (state == IDLE)      ? (pop ? LAUNCH : IDLE) :
               (state == LAUNCH)    ? WAIT_BUSY :
               (state == WAIT_BUSY) ? (tx_ready ? WAIT_BUSY : WAIT_DONE) :
                                      (tx_ready ? IDLE : WAIT_DONE);
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      state    <= IDLE;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + ADDR_W'(1);
        tx_data <= mem[rd_ptr];
      end
      state    <= state_nx;
      count    <= count_nx;
      empty    <= count_nx == '0;
      full     <= count_nx == FULL_CNT;
      overflow <= overflow | (in_valid & full & ~pop);
      tx_start <= pop;
    end
endmodule

// File: tb/tb_relay_fifo.sv
// tb_relay_fifo: directed tests for relay_fifo checked against a queue model of the relay buffer.
module tb_relay_fifo;
  localparam int DEPTH = 16;
  logic clk = 0;
  logic rst, in_valid, tx_ready, tx_start, empty, full, overflow;
  logic [7:0] in_data, tx_data;
  logic [4:0] count;
  logic hold = 0;
  int busy = 0;
  int n_chk = 0, n_fail = 0;
  logic [7:0] mq[$];
  logic [7:0] sent[$];
  logic movf;
  relay_fifo #(.DEPTH(DEPTH), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .tx_ready(tx_ready),
    .tx_start(tx_start), .tx_data(tx_data), .count(count), .empty(empty), .full(full),
    .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [7:0] d);
    in_valid = 1;
    in_data = d;
    tick();
    in_valid = 0;
  endtask
  task automatic wait_drain(input int n);
    for (int k = 0; k < 3000 && !(sent.size() >= n && empty); k++) tick();
    chk("drain_timeout", sent.size() >= n, 1);
  endtask
  // transmitter model: goes busy on the negedge it sees start, idle 3 negedges later
  initial begin
    tx_ready = 1;
    forever begin
      @(negedge clk);
      if (tx_start) busy = 3;
      else if (busy > 0) busy--;
      tx_ready = !hold && busy == 0;
    end
  end
  initial begin
    logic pv, pr, prst, prev_start;
    logic [7:0] pd;
    int sz, phase;
    phase = 2;
    prev_start = 0;
    movf = 0;
    forever begin
      @(posedge clk);
      pv = in_valid; pd = in_data; pr = tx_ready; prst = rst;
      @(negedge clk);
      if (rst || prst) begin
        mq.delete();
        movf = 0;
        phase = 2;
        prev_start = 0;
        if (rst) begin
          chk("rst_count", count, 0);
          chk("rst_empty", empty, 1);
          chk("rst_full", full, 0);
          chk("rst_start", tx_start, 0);
          chk("rst_ovf", overflow, 0);
          chk("rst_data", tx_data, 0);
        end
      end else begin
        sz = mq.size();
        if (tx_start) begin
          chk("start_twice", prev_start, 0);
          chk("start_ready", pr, 1);
          chk("start_gap", phase == 2, 1);
          chk("pop_nonempty", sz != 0, 1);
          if (sz != 0) begin
            chk("tx_data", tx_data, mq[0]);
            void'(mq.pop_front());
          end
          sent.push_back(tx_data);
          phase = 0;
        end else if (!pr && phase == 0) phase = 1;
        else if (pr && phase == 1) phase = 2;
        if (pv) begin
          if (sz < DEPTH || tx_start) mq.push_back(pd);
          else movf = 1;
        end
        chk("count", count, mq.size());
        chk("empty", empty, mq.size() == 0);
        chk("full", full, mq.size() == DEPTH);
        chk("overflow", overflow, movf);
        prev_start = tx_start;
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int base;
    rst = 1; in_valid = 0; in_data = 0;
    repeat (3) tick();
    chk("init_count", count, 0);
    chk("init_empty", empty, 1);
    chk("init_data", tx_data, 0);
    rst = 0;
    repeat (3) tick();
    // single byte latency
    base = sent.size();
    push(8'hA5);
    chk("lat_count1", count, 1);
    chk("lat_nostart", tx_start, 0);
    tick();
    chk("lat_start", tx_start, 1);
    chk("lat_data", tx_data, 8'hA5);
    chk("lat_count0", count, 0);
    tick();
    chk("lat_pulse", tx_start, 0);
    wait_drain(base + 1);
    repeat (10) tick();
    // burst while busy
    base = sent.size();
    hold = 1;
    for (int i = 1; i <= 5; i++) push(8'(i));
    tick();
    chk("burst_count", count, 5);
    chk("burst_nostart", sent.size(), base);
    hold = 0;
    wait_drain(base + 5);
    for (int i = 0; i < 5; i++) chk("burst_order", sent[base+i], i + 1);
    chk("burst_empty", empty, 1);
    repeat (10) tick();
    // simultaneous push and pop on a 1-entry FIFO
    base = sent.size();
    hold = 1;
    push(8'hC1);
    tick();
    chk("sim_count_pre", count, 1);
    hold = 0;
    in_valid = 1;
    in_data = 8'hC2;
    tick();
    in_valid = 0;
    chk("sim_count", count, 1);
    chk("sim_start", tx_start, 1);
    chk("sim_data", tx_data, 8'hC1);
    wait_drain(base + 2);
    chk("sim_next", sent[base+1], 8'hC2);
    repeat (10) tick();
    // wrap-around
    base = sent.size();
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 3; k++) push(8'(8'h40 + r * 3 + k));
      wait_drain(base + r * 3 + 3);
    end
    for (int i = 0; i < 30; i++) chk("wrap_order", sent[base+i], 8'h40 + i);
    chk("wrap_ovf", overflow, 0);
    repeat (10) tick();
    // overflow
    base = sent.size();
    hold = 1;
    for (int i = 1; i <= 17; i++) push(8'(i));
    tick();
    chk("ovf_count", count, 16);
    chk("ovf_full", full, 1);
    chk("ovf_flag", overflow, 1);
    hold = 0;
    wait_drain(base + 16);
    repeat (50) tick();
    chk("ovf_sent", sent.size(), base + 16);
    for (int i = 0; i < 16; i++) chk("ovf_order", sent[base+i], i + 1);
    chk("ovf_sticky", overflow, 1);
    repeat (10) tick();
    // reset while in WAIT_BUSY with 4 queued
    hold = 1;
    for (int i = 0; i < 5; i++) push(8'(8'h90 + i));
    hold = 0;
    for (int k = 0; k < 50 && !tx_start; k++) tick();
    chk("rst_launch", tx_start, 1);
    tick();
    chk("rst_pre_count", count, 4);
    #1 rst = 1;
    #1;
    chk("amid_count", count, 0);
    chk("amid_empty", empty, 1);
    chk("amid_start", tx_start, 0);
    chk("amid_ovf", overflow, 0);
    @(posedge clk);
    #1 rst = 0;
    base = sent.size();
    repeat (20) tick();
    chk("post_rst_nostart", sent.size(), base);
    push(8'h77);
    wait_drain(base + 1);
    chk("post_rst_data", sent[base], 8'h77);
    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
